// File: rtl/irq_cond_pkg.sv
// rtl/irq_cond_pkg.sv - shared line indices, types and helpers for the irq conditioning stage
package irq_cond_pkg;

  localparam int unsigned NrIrqLines  = 5;
  localparam int unsigned IrqLineM    = 0;
  localparam int unsigned IrqLineS    = 1;
  localparam int unsigned IrqLineIpi  = 2;
  localparam int unsigned IrqLineTime = 3;
  localparam int unsigned IrqLineDbg  = 4;

  typedef logic [NrIrqLines-1:0] irq_lines_t;

  function automatic logic [2:0] count_lines(input irq_lines_t v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NrIrqLines; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/irq_filter_line.sv
// rtl/irq_filter_line.sv - synchronizer plus persistence filter for one async request line
module irq_filter_line #(
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned FilterCycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic f_o,
  output logic glitch_o
);

  localparam logic [3:0] LastCnt = 4'(FilterCycles - 1);

  logic [SyncStages-1:0] r_sync;
  logic                  r_f;
  logic [3:0]            r_cnt;
  logic                  w_s;

  assign w_s = r_sync[SyncStages-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync <= '0;
      r_f    <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[SyncStages-2:0], d_i};
      if (w_s == r_f) begin
        r_cnt <= '0;
      end else if (r_cnt == LastCnt) begin
        r_f   <= w_s;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  // A partial count abandoned because the line fell back is a rejected glitch.
  assign glitch_o = (w_s == r_f) && (r_cnt != 4'd0);
  assign f_o      = r_f;

endmodule

// File: rtl/ariane_irq_cond.sv
// rtl/ariane_irq_cond.sv - conditions raw irq/ipi/timer/debug lines for the core and counts glitches
module ariane_irq_cond
  import irq_cond_pkg::*;
#(
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned FilterCycles = 4,
  parameter int unsigned DebugPulse   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            irq_i,
  input  logic                  ipi_i,
  input  logic                  time_irq_i,
  input  logic                  debug_req_i,
  input  logic [NrIrqLines-1:0] mask_i,
  input  logic                  glitch_clr_i,
  output logic [1:0]            irq_o,
  output logic                  ipi_o,
  output logic                  time_irq_o,
  output logic                  debug_req_o,
  output logic [NrIrqLines-1:0] level_o,
  output logic [7:0]            glitch_cnt_o
);

  irq_lines_t w_raw;
  irq_lines_t w_f;
  irq_lines_t w_glitch;
  irq_lines_t r_out;
  logic       r_f4_old;
  logic [7:0] r_cnt;
  logic       w_dbg;
  logic [8:0] w_sum;

  assign w_raw = {debug_req_i, time_irq_i, ipi_i, irq_i};

  for (genvar i = 0; i < NrIrqLines; i++) begin : g_line
    irq_filter_line #(
      .SyncStages  (SyncStages),
      .FilterCycles(FilterCycles)
    ) u_line (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .d_i     (w_raw[i]),
      .f_o     (w_f[i]),
      .glitch_o(w_glitch[i])
    );
  end

  // Pulse mode looks at the filtered level, so a masked edge is simply gone.
  assign w_dbg = (DebugPulse != 0) ? (w_f[IrqLineDbg] & ~r_f4_old) : w_f[IrqLineDbg];
  assign w_sum = {1'b0, r_cnt} + {6'b0, count_lines(w_glitch)};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_out    <= '0;
      r_f4_old <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_out[IrqLineTime:0] <= w_f[IrqLineTime:0] & ~mask_i[IrqLineTime:0];
      r_out[IrqLineDbg]    <= w_dbg & ~mask_i[IrqLineDbg];
      r_f4_old             <= w_f[IrqLineDbg];
      if (glitch_clr_i) begin
        r_cnt <= '0;
      end else if (w_sum > 9'd255) begin
        r_cnt <= 8'hFF;
      end else begin
        r_cnt <= w_sum[7:0];
      end
    end
  end

  assign irq_o        = r_out[IrqLineS:IrqLineM];
  assign ipi_o        = r_out[IrqLineIpi];
  assign time_irq_o   = r_out[IrqLineTime];
  assign debug_req_o  = r_out[IrqLineDbg];
  assign level_o      = w_f;
  assign glitch_cnt_o = r_cnt;

endmodule
